// File: rtl/uart_tx_baud_pkg.sv
// Shared definitions for the baud-clocked UART transmitter: state encoding,
// default frame width and the parity helper.
package uart_tx_baud_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   localparam int UART_DATA_BITS_DEFAULT = 8;

   // Data narrower than 8 bits is zero-extended by the caller; zeros do not
   // change the XOR, so one helper serves every frame width.
   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for bus-side control signals entering a
// peripheral clock domain; resets to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_baud.sv
// UART transmitter clocked at the bit rate: one byte per 4-phase req/ack
// handshake, sent as start, data LSB first, optional parity, stop bit(s).
module uart_tx_baud
   import uart_tx_baud_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clkin,
   input  logic                 reset,
   input  logic                 tx_req,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ack,
   output logic                 tx_busy,
   output logic                 tx
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   logic                 req_s;
   state_e               state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [2:0]           cnt_q;
   logic                 tx_q;
   logic                 ack_q;
   logic                 busy_q;
   logic                 par_q;
   logic                 par_d;
   logic                 capture_d;

   sync_2ff #(
      .WIDTH (1)
   ) u_req_sync (
      .clk_i  (clkin),
      .rst_ni (reset),
      .d_i    (tx_req),
      .q_o    (req_s)
   );

   // A new byte is taken only once the previous ack has been withdrawn, so a
   // held-high request yields a single frame.
   assign capture_d = req_s & ~ack_q;
   assign shift_d   = shift_q >> 1;
   assign par_d     = parity_of(8'(tx_data), PARITY_ODD);

   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= 3'd0;
         tx_q    <= 1'b1;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         if (!req_s) begin
            ack_q <= 1'b0;
         end

         unique case (state_q)
            ST_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (capture_d) begin
                  shift_q <= tx_data;
                  par_q   <= par_d;
                  ack_q   <= 1'b1;
                  cnt_q   <= 3'd0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_START;
               end
            end

            ST_START: begin
               tx_q    <= shift_q[0];
               shift_q <= shift_d;
               cnt_q   <= 3'd0;
               state_q <= ST_DATA;
            end

            // cnt_q numbers the data bit currently on the line.
            ST_DATA: begin
               if (cnt_q == LAST_DATA) begin
                  cnt_q <= 3'd0;
                  if (PARITY_EN) begin
                     tx_q    <= par_q;
                     state_q <= ST_PARITY;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end
               end else begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_d;
                  cnt_q   <= cnt_q + 3'd1;
               end
            end

            ST_PARITY: begin
               tx_q    <= 1'b1;
               cnt_q   <= 3'd0;
               state_q <= ST_STOP;
            end

            // Leaving the last stop bit may start the next frame directly.
            ST_STOP: begin
               if (cnt_q == LAST_STOP) begin
                  cnt_q <= 3'd0;
                  if (capture_d) begin
                     shift_q <= tx_data;
                     par_q   <= par_d;
                     ack_q   <= 1'b1;
                     tx_q    <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= ST_START;
                  end else begin
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  tx_q  <= 1'b1;
                  cnt_q <= cnt_q + 3'd1;
               end
            end

            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= 3'd0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx      = tx_q;
   assign tx_ack  = ack_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Directed bench for uart_tx_baud: three parameterisations share clock,
// reset and request; each test inspects the instance it targets.
module tb_uart_tx_baud;

   logic       clkin = 1'b0;
   logic       reset;
   logic       tx_req;
   logic [7:0] tx_data;
   logic [2:0] tx_w;
   logic [2:0] ack_w;
   logic [2:0] busy_w;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clkin = ~clkin;

   // 0: 8N1   1: 8E1   2: 8O2
   uart_tx_baud #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_def (
      .clkin(clkin), .reset(reset), .tx_req(tx_req), .tx_data(tx_data),
      .tx_ack(ack_w[0]), .tx_busy(busy_w[0]), .tx(tx_w[0]));

   uart_tx_baud #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_pe (
      .clkin(clkin), .reset(reset), .tx_req(tx_req), .tx_data(tx_data),
      .tx_ack(ack_w[1]), .tx_busy(busy_w[1]), .tx(tx_w[1]));

   uart_tx_baud #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_po (
      .clkin(clkin), .reset(reset), .tx_req(tx_req), .tx_data(tx_data),
      .tx_ack(ack_w[2]), .tx_busy(busy_w[2]), .tx(tx_w[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      tx_req = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
   endtask

   // Raises tx_req and checks the ack appears on the 3rd edge, not the 2nd.
   task automatic request(input int sel, input logic [7:0] d, input string tag);
      tx_data = d;
      tx_req  = 1'b1;
      tick();
      tick();
      chk({tag, "_ack_edge2"}, ack_w[sel], 1'b0);
      tick();
      chk({tag, "_ack_edge3"}, ack_w[sel], 1'b1);
   endtask

   // bits holds the expected line levels, first bit in the MSB of len bits.
   task automatic run_frame(input int sel, input logic [31:0] bits, input int len, input string tag);
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s_tx%0d", tag, i), tx_w[sel], bits[len-1-i]);
         chk($sformatf("%s_busy%0d", tag, i), busy_w[sel], 1'b1);
         tick();
      end
      chk({tag, "_idle_tx"}, tx_w[sel], 1'b1);
      chk({tag, "_idle_busy"}, busy_w[sel], 1'b0);
   endtask

   task automatic release_req(input int sel, input string tag);
      tx_req = 1'b0;
      tick();
      tick();
      chk({tag, "_ack_hold"}, ack_w[sel], 1'b1);
      tick();
      chk({tag, "_ack_clr"}, ack_w[sel], 1'b0);
   endtask

   // 0x00 then 0xFF; tx_req follows tx_ack as closely as the handshake allows.
   task automatic b2b(input int sel, input logic [31:0] bits, input int len, input string tag);
      int raised;
      tx_data = 8'h00;
      tx_req  = 1'b1;
      raised  = 1;
      repeat (3) tick();
      chk({tag, "_ack1"}, ack_w[sel], 1'b1);
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s_tx%0d", tag, i), tx_w[sel], bits[len-1-i]);
         chk($sformatf("%s_busy%0d", tag, i), busy_w[sel], 1'b1);
         if (i == len / 2) chk({tag, "_ack2"}, ack_w[sel], 1'b1);
         if (ack_w[sel] && tx_req) begin
            tx_req = 1'b0;
         end else if (!ack_w[sel] && !tx_req && raised == 1) begin
            tx_req  = 1'b1;
            tx_data = 8'hFF;
            raised  = 2;
         end
         tick();
      end
      chk({tag, "_end_tx"}, tx_w[sel], 1'b1);
      chk({tag, "_end_busy"}, busy_w[sel], 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      tx_req  = 1'b0;
      tx_data = 8'h00;
      repeat (2) tick();
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("rst_tx_%0d", s), tx_w[s], 1'b1);
         chk($sformatf("rst_ack_%0d", s), ack_w[s], 1'b0);
         chk($sformatf("rst_busy_%0d", s), busy_w[s], 1'b0);
      end
      reset = 1'b1;
      tick();

      // 0x55, 8N1
      request(0, 8'h55, "b55");
      run_frame(0, 32'b0101010101, 10, "b55");
      chk("b55_ack_after", ack_w[0], 1'b1);
      release_req(0, "b55");

      // 0x07 with even parity, then odd parity and two stop bits
      do_reset();
      request(1, 8'h07, "even07");
      run_frame(1, 32'b01110000011, 11, "even07");
      release_req(1, "even07");

      do_reset();
      request(2, 8'h07, "odd07");
      run_frame(2, 32'b011100000011, 12, "odd07");
      release_req(2, "odd07");

      // Held request: one frame only
      do_reset();
      request(0, 8'hA3, "hold");
      run_frame(0, 32'b0110001011, 10, "hold");
      for (int i = 0; i < 26; i++) begin
         tick();
         chk($sformatf("hold_idle_tx%0d", i), tx_w[0], 1'b1);
         chk($sformatf("hold_idle_busy%0d", i), busy_w[0], 1'b0);
      end
      chk("hold_ack_held", ack_w[0], 1'b1);
      release_req(0, "hold");

      // Back-to-back frames
      do_reset();
      b2b(0, 32'b00000000010111111111, 20, "b2b1");
      do_reset();
      b2b(2, 32'b000000000111011111111111, 24, "b2b2");

      // Reset during data bit 4 of 0x3C
      do_reset();
      request(0, 8'h3C, "rst3c");
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rst3c_tx%0d", i), tx_w[0], (6'b000111 >> (5 - i)) & 1);
         if (i < 5) tick();
      end
      #1 reset = 1'b0;
      #1;
      chk("rst3c_now_tx", tx_w[0], 1'b1);
      chk("rst3c_now_busy", busy_w[0], 1'b0);
      chk("rst3c_now_ack", ack_w[0], 1'b0);
      tx_req = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("rst3c_after_tx%0d", i), tx_w[0], 1'b1);
         chk($sformatf("rst3c_after_busy%0d", i), busy_w[0], 1'b0);
      end

      // tx_data changes after capture
      do_reset();
      request(0, 8'h12, "chg");
      chk("chg_start", tx_w[0], 1'b0);
      tick();
      tx_data = 8'hEF;
      run_frame(0, 32'b010010001, 9, "chg");
      release_req(0, "chg");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
